mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-port accelerator memory interface between three requesters: pixel reads, weight reads and output writes. It sits between the cgra4ml datapath's `o_rd_pixel` / `o_rd_weights` / `o_we_output` style ports and a single RAM or AXI-to-RAM bridge. Grants are round-robin with a bounded burst hold, so back-to-back streaming stays efficient and no requester starves. Read data returns with a fixed one-cycle latency, tagged to the requester that issued it.

## Interface
Parameters:
- `DATA_W`, 128, memory word width (matches `AXI_WIDTH`).
- `ADDR_W`, 28, word address width (32 − log2(DATA_W/8)).
- `MAX_BURST`, 4, maximum consecutive grants to one requester while another is pending; ≥1.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `pixel_req`  in  1  pixel read request; held with address until granted.
- `pixel_addr`  in  ADDR_W  pixel word address.
- `pixel_gnt`  out  1  beat accepted this cycle.
- `pixel_rvalid`  out  1  `pixel_rdata` valid.
- `pixel_rdata`  out  DATA_W  read data.
- `weights_req`, `weights_addr`, `weights_gnt`, `weights_rvalid`, `weights_rdata`  same as the pixel set, for weights.
- `out_req`  in  1  output write request.
- `out_addr`  in  ADDR_W  write word address.
- `out_wdata`  in  DATA_W  write data.
- `out_wstrb`  in  DATA_W/8  byte strobes.
- `out_gnt`  out  1  write accepted this cycle.
- `mem_rd`  out  1  memory read strobe.
- `mem_raddr`  out  ADDR_W  read address.
- `mem_rdata`  in  DATA_W  valid the cycle after `mem_rd`.
- `mem_we`  out  1  memory write strobe.
- `mem_waddr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_wstrb`  out  DATA_W/8  write strobes.
- `busy`  out  1  a grant was issued this cycle, or read data is in flight.

## Operation
- State: `owner` (2-bit: PIX=0, WGT=1, OUT=2), `burst_cnt` (counts 0..MAX_BURST), and registered `rtag` (2 bits: pixel/weights read in flight).
- Exactly one grant per cycle at most. `mem_rd` and `mem_we` are never high together.
- Hold rule: if `owner` requests and (`burst_cnt` < MAX_BURST, or no other requester pending), grant `owner` again and saturate-increment `burst_cnt`.
- Otherwise rotate. Search order starts after `owner` (PIX→WGT→OUT→PIX). The first requester found is granted, `owner` becomes that requester, and `burst_cnt` is set to 1.
- A cycle with no grant clears `burst_cnt` to 0 and leaves `owner` unchanged.
- Grant and memory outputs are combinational from req and state in the same cycle.
  - Pixel or weights grant: `mem_rd`=1, `mem_raddr` = that address.
  - Out grant: `mem_we`=1 with the out address, data and strobes.
  - Idle cycle: address, data and strobes are 0.
- Read return: `rtag` registers which read was granted. Next cycle, the matching `*_rvalid`=1 and both `*_rdata` = `mem_rdata`; the non-matching rvalid stays 0.
- There is no backpressure on read return; requesters must accept data.
- Requester contract: `req` and its payload stay stable until `gnt`. Dropping `req` before grant is permitted and is simply never serviced.

## Timing
- Reset (rstn low, async):
  - `owner`=OUT, so pixel wins first.
  - `burst_cnt`=0, `rtag`=none.
  - All `*_gnt`, `*_rvalid`, `mem_rd`, `mem_we`, `busy` = 0 and addresses/data = 0.
  - Grants are forced 0 while rstn is low.
- Read latency: request granted in cycle N gives rvalid in cycle N+1. Sustained throughput is one beat per cycle.
- Write latency: `mem_we` is issued in the grant cycle; no response is returned.
- Simultaneous requests are resolved only by the hold/rotate rules; there is no fixed priority.
- Reset mid-flight: any pending rvalid is dropped and no rvalid is emitted after rstn deasserts until a new read grant.
- `MAX_BURST`=1 gives pure round-robin.

## Test plan
- Reset: hold rstn low with all reqs high → all gnt, mem_rd, mem_we, rvalid = 0. First cycle after release → `pixel_gnt`=1.
- Single read: `pixel_req` with addr 0x10 for 1 cycle → `mem_rd`=1, `mem_raddr`=0x10. Next cycle, drive `mem_rdata`=0xA5…A5 → `pixel_rvalid`=1 with that data, `weights_rvalid`=0.
- Burst hold: weights and out requesting continuously, MAX_BURST=4 → grant sequence W,W,W,W,O,O,O,O,W…; `mem_rd` and `mem_we` are never both 1.
- Three-way contention with MAX_BURST=1, all reqs held → P,W,O,P,W,O. Each read rvalid arrives 1 cycle after its grant with the correct tag.
- Solo requester: only `out_req`, for 10 cycles → 10 consecutive `out_gnt` (no forced rotation). Strobes 0x00FF are passed through to `mem_wstrb`.
- Idle gap: weights granted, then 1 idle cycle, then weights and pixel both request → pixel granted (rotation after owner=WGT). `burst_cnt` restarts at 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between pixel reads, weight reads and output
// writes. Round-robin grants with a bounded burst hold; read data comes back
// one cycle after the grant, flagged to the requester that issued the read.

module mem_port_arbiter #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 28,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                pixel_req,
    input  logic [ADDR_W-1:0]   pixel_addr,
    output logic                pixel_gnt,
    output logic                pixel_rvalid,
    output logic [DATA_W-1:0]   pixel_rdata,

    input  logic                weights_req,
    input  logic [ADDR_W-1:0]   weights_addr,
    output logic                weights_gnt,
    output logic                weights_rvalid,
    output logic [DATA_W-1:0]   weights_rdata,

    input  logic                out_req,
    input  logic [ADDR_W-1:0]   out_addr,
    input  logic [DATA_W-1:0]   out_wdata,
    input  logic [DATA_W/8-1:0] out_wstrb,
    output logic                out_gnt,

    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,

    output logic                busy
);

    localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_PIX = 2'd0,
        OWN_WGT = 2'd1,
        OWN_OUT = 2'd2
    } owner_t;

    owner_t           owner;
    owner_t           next_owner;
    logic [CNT_W-1:0] burst_cnt;
    logic [1:0]       rtag;       // bit 0: pixel read in flight, bit 1: weights read in flight

    logic [2:0]       req_vec;
    logic [2:0]       gnt_vec;
    logic             own_req;
    logic             others_pending;
    logic             hold;

    // Grant selection. A burst_cnt of 0 means no burst is in progress (reset or
    // an idle cycle), so the owner only keeps the port while it is actively
    // bursting; otherwise the search starts with the requester after the owner.
    always_comb begin
        req_vec        = {out_req, weights_req, pixel_req};
        gnt_vec        = 3'b000;
        own_req        = 1'b0;
        others_pending = 1'b0;
        case (owner)
            OWN_PIX: begin
                own_req        = req_vec[0];
                others_pending = req_vec[1] | req_vec[2];
            end
            OWN_WGT: begin
                own_req        = req_vec[1];
                others_pending = req_vec[0] | req_vec[2];
            end
            default: begin
                own_req        = req_vec[2];
                others_pending = req_vec[0] | req_vec[1];
            end
        endcase
        hold = rstn && (burst_cnt != '0) && own_req
               && ((burst_cnt < MAX_CNT) || !others_pending);
        if (!rstn) begin
            gnt_vec = 3'b000;
        end else if (hold) begin
            case (owner)
                OWN_PIX: gnt_vec = 3'b001;
                OWN_WGT: gnt_vec = 3'b010;
                default: gnt_vec = 3'b100;
            endcase
        end else begin
            case (owner)
                OWN_PIX: begin
                    if      (req_vec[1]) gnt_vec = 3'b010;
                    else if (req_vec[2]) gnt_vec = 3'b100;
                    else if (req_vec[0]) gnt_vec = 3'b001;
                end
                OWN_WGT: begin
                    if      (req_vec[2]) gnt_vec = 3'b100;
                    else if (req_vec[0]) gnt_vec = 3'b001;
                    else if (req_vec[1]) gnt_vec = 3'b010;
                end
                default: begin
                    if      (req_vec[0]) gnt_vec = 3'b001;
                    else if (req_vec[1]) gnt_vec = 3'b010;
                    else if (req_vec[2]) gnt_vec = 3'b100;
                end
            endcase
        end
        if (gnt_vec[0])      next_owner = OWN_PIX;
        else if (gnt_vec[1]) next_owner = OWN_WGT;
        else                 next_owner = OWN_OUT;
    end

    // Owner, burst length and read-return tag; reset hands pixel the first turn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner     <= OWN_OUT;
            burst_cnt <= '0;
            rtag      <= 2'b00;
        end else begin
            rtag <= gnt_vec[1:0];
            if (gnt_vec == 3'b000) begin
                burst_cnt <= '0;
            end else if (hold) begin
                if (burst_cnt != MAX_CNT) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                owner     <= next_owner;
                burst_cnt <= CNT_W'(1);
            end
        end
    end

    // Memory strobes and payload follow the grant in the same cycle; zero when idle.
    always_comb begin
        pixel_gnt   = gnt_vec[0];
        weights_gnt = gnt_vec[1];
        out_gnt     = gnt_vec[2];
        mem_rd      = gnt_vec[0] | gnt_vec[1];
        mem_we      = gnt_vec[2];
        if (gnt_vec[0])      mem_raddr = pixel_addr;
        else if (gnt_vec[1]) mem_raddr = weights_addr;
        else                 mem_raddr = '0;
        mem_waddr = gnt_vec[2] ? out_addr  : '0;
        mem_wdata = gnt_vec[2] ? out_wdata : '0;
        mem_wstrb = gnt_vec[2] ? out_wstrb : '0;
    end

    // Read return: both data buses carry the memory word, only the tagged rvalid rises.
    always_comb begin
        pixel_rvalid   = rtag[0];
        weights_rvalid = rtag[1];
        pixel_rdata    = (|rtag) ? mem_rdata : '0;
        weights_rdata  = (|rtag) ? mem_rdata : '0;
        busy           = (|gnt_vec) | (|rtag);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (burst limit 4 and 1) share the
// same stimulus and are checked every cycle against a requester-level model.

module tb_mem_port_arbiter;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 28;
    localparam int STRB_W = DATA_W / 8;

    logic                clk;
    logic                rstn;
    logic                pixel_req;
    logic [ADDR_W-1:0]   pixel_addr;
    logic                weights_req;
    logic [ADDR_W-1:0]   weights_addr;
    logic                out_req;
    logic [ADDR_W-1:0]   out_addr;
    logic [DATA_W-1:0]   out_wdata;
    logic [STRB_W-1:0]   out_wstrb;
    logic [DATA_W-1:0]   mem_rdata;

    logic                pixel_gnt      [2];
    logic                pixel_rvalid   [2];
    logic [DATA_W-1:0]   pixel_rdata    [2];
    logic                weights_gnt    [2];
    logic                weights_rvalid [2];
    logic [DATA_W-1:0]   weights_rdata  [2];
    logic                out_gnt        [2];
    logic                mem_rd         [2];
    logic [ADDR_W-1:0]   mem_raddr      [2];
    logic                mem_we         [2];
    logic [ADDR_W-1:0]   mem_waddr      [2];
    logic [DATA_W-1:0]   mem_wdata      [2];
    logic [STRB_W-1:0]   mem_wstrb      [2];
    logic                busy           [2];

    int n_compared;
    int n_mismatched;

    // Model state per instance: owner 0=pixel 1=weights 2=out, burst length,
    // and which read (0 none, 1 pixel, 2 weights) is returning next cycle.
    int m_owner [2];
    int m_burst [2];
    int m_tag   [2];
    int max_b   [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_port_arbiter #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .MAX_BURST((gi == 0) ? 4 : 1)
        ) u_dut (
            .clk(clk),
            .rstn(rstn),
            .pixel_req(pixel_req),
            .pixel_addr(pixel_addr),
            .pixel_gnt(pixel_gnt[gi]),
            .pixel_rvalid(pixel_rvalid[gi]),
            .pixel_rdata(pixel_rdata[gi]),
            .weights_req(weights_req),
            .weights_addr(weights_addr),
            .weights_gnt(weights_gnt[gi]),
            .weights_rvalid(weights_rvalid[gi]),
            .weights_rdata(weights_rdata[gi]),
            .out_req(out_req),
            .out_addr(out_addr),
            .out_wdata(out_wdata),
            .out_wstrb(out_wstrb),
            .out_gnt(out_gnt[gi]),
            .mem_rd(mem_rd[gi]),
            .mem_raddr(mem_raddr[gi]),
            .mem_rdata(mem_rdata),
            .mem_we(mem_we[gi]),
            .mem_waddr(mem_waddr[gi]),
            .mem_wdata(mem_wdata[gi]),
            .mem_wstrb(mem_wstrb[gi]),
            .busy(busy[gi])
        );
    end

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input int inst,
                           input logic [DATA_W-1:0] observed,
                           input logic [DATA_W-1:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, observed, expected);
        end
    endtask

    // Rule-level arbitration: keep an active burst while allowed, else take the
    // first requester after the owner in circular order.
    function automatic int pickGrant(input int own, input int burst, input int maxb,
                                     input bit [2:0] rq);
        int others;
        others = 0;
        for (int k = 0; k < 3; k++) begin
            if (k != own && rq[k]) others++;
        end
        if (burst > 0 && rq[own] && (burst < maxb || others == 0)) return own;
        for (int k = 1; k <= 3; k++) begin
            if (rq[(own + k) % 3]) return (own + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] grantsOf(input int i);
        return {out_gnt[i], weights_gnt[i], pixel_gnt[i]};
    endfunction

    // Drive one cycle of inputs on the falling edge; idle payloads get fresh random values.
    task automatic applyStimulus(input logic rn, input logic p, input logic w, input logic o);
        @(negedge clk);
        rstn        = rn;
        pixel_req   = p;
        weights_req = w;
        out_req     = o;
        mem_rdata   = {$urandom, $urandom, $urandom, $urandom};
        if (!p) pixel_addr   = ADDR_W'($urandom);
        if (!w) weights_addr = ADDR_W'($urandom);
        if (!o) begin
            out_addr  = ADDR_W'($urandom);
            out_wdata = {$urandom, $urandom, $urandom, $urandom};
            out_wstrb = STRB_W'($urandom);
        end
    endtask

    // Compare every output of one instance with the model, then advance the model.
    task automatic checkOutput(input int i);
        bit [2:0]          rq;
        int                g;
        logic [2:0]        e_gnt;
        logic [ADDR_W-1:0] e_raddr;
        logic [ADDR_W-1:0] e_waddr;
        logic [DATA_W-1:0] e_wdata;
        logic [STRB_W-1:0] e_wstrb;
        logic [DATA_W-1:0] e_rdata;
        rq = {out_req, weights_req, pixel_req};
        if (!rstn) begin
            m_owner[i] = 2;
            m_burst[i] = 0;
            m_tag[i]   = 0;
            g          = -1;
        end else begin
            g = pickGrant(m_owner[i], m_burst[i], max_b[i], rq);
        end
        e_gnt   = (g >= 0) ? (3'b001 << g) : 3'b000;
        e_raddr = (g == 0) ? pixel_addr : ((g == 1) ? weights_addr : '0);
        e_waddr = (g == 2) ? out_addr  : '0;
        e_wdata = (g == 2) ? out_wdata : '0;
        e_wstrb = (g == 2) ? out_wstrb : '0;
        e_rdata = (m_tag[i] != 0) ? mem_rdata : '0;

        compare("gnt", i, DATA_W'(grantsOf(i)), DATA_W'(e_gnt));
        compare("mem_rd", i, DATA_W'(mem_rd[i]), DATA_W'(g == 0 || g == 1));
        compare("mem_we", i, DATA_W'(mem_we[i]), DATA_W'(g == 2));
        compare("rd_we_both", i, DATA_W'(mem_rd[i] & mem_we[i]), '0);
        compare("mem_raddr", i, DATA_W'(mem_raddr[i]), DATA_W'(e_raddr));
        compare("mem_waddr", i, DATA_W'(mem_waddr[i]), DATA_W'(e_waddr));
        compare("mem_wdata", i, mem_wdata[i], e_wdata);
        compare("mem_wstrb", i, DATA_W'(mem_wstrb[i]), DATA_W'(e_wstrb));
        compare("pixel_rvalid", i, DATA_W'(pixel_rvalid[i]), DATA_W'(m_tag[i] == 1));
        compare("weights_rvalid", i, DATA_W'(weights_rvalid[i]), DATA_W'(m_tag[i] == 2));
        compare("pixel_rdata", i, pixel_rdata[i], e_rdata);
        compare("weights_rdata", i, weights_rdata[i], e_rdata);
        compare("busy", i, DATA_W'(busy[i]), DATA_W'(g >= 0 || m_tag[i] != 0));

        if (rstn) begin
            m_tag[i] = (g == 0) ? 1 : ((g == 1) ? 2 : 0);
            if (g < 0) begin
                m_burst[i] = 0;
            end else if (g == m_owner[i] && m_burst[i] > 0) begin
                if (m_burst[i] < max_b[i]) m_burst[i]++;
            end else begin
                m_owner[i] = g;
                m_burst[i] = 1;
            end
        end
    endtask

    task automatic cycleStep();
        #1;
        checkOutput(0);
        checkOutput(1);
    endtask

    // Directed scenarios followed by a randomized run, all in one linear sequence.
    initial begin
        int seq_mb4 [10];
        int seq_mb1 [5];
        n_compared   = 0;
        n_mismatched = 0;
        max_b[0] = 4;
        max_b[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = 2;
            m_burst[i] = 0;
            m_tag[i]   = 0;
        end
        rstn         = 1'b0;
        pixel_req    = 1'b1;
        weights_req  = 1'b1;
        out_req      = 1'b1;
        pixel_addr   = '0;
        weights_addr = '0;
        out_addr     = '0;
        out_wdata    = '0;
        out_wstrb    = '0;
        mem_rdata    = '0;

        // Reset held with every requester asserted: nothing may be granted.
        repeat (3) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
            cycleStep();
        end

        // Release with all requesting: pixel first, then strict rotation for burst limit 1.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        cycleStep();
        compare("first_after_reset", 0, DATA_W'(grantsOf(0)), DATA_W'(3'b001));
        compare("first_after_reset", 1, DATA_W'(grantsOf(1)), DATA_W'(3'b001));
        seq_mb1 = '{1, 2, 0, 1, 2};
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
            cycleStep();
            compare("rr_seq", 1, DATA_W'(grantsOf(1)), DATA_W'(3'b001 << seq_mb1[c]));
        end

        // Single pixel read of word 0x10 and its data return one cycle later.
        repeat (2) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            cycleStep();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        pixel_addr = ADDR_W'(28'h10);
        cycleStep();
        compare("single_raddr", 0, DATA_W'(mem_raddr[0]), DATA_W'(28'h10));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        mem_rdata = {16{8'hA5}};
        cycleStep();
        compare("single_rdata", 0, pixel_rdata[0], {16{8'hA5}});

        // Weights and out both streaming after a fresh reset: bursts of four each.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        cycleStep();
        seq_mb4 = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
            cycleStep();
            compare("burst_seq", 0, DATA_W'(grantsOf(0)), DATA_W'(3'b001 << seq_mb4[c]));
        end

        // Reset while a pixel read is in flight drops the return.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        cycleStep();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        cycleStep();
        repeat (2) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            cycleStep();
        end

        // Out alone for ten cycles: never forced off the port, strobes pass through.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            out_wstrb = STRB_W'(16'h00FF);
            cycleStep();
            compare("solo_out_gnt", 0, DATA_W'(out_gnt[0]), DATA_W'(1'b1));
            compare("solo_wstrb", 0, DATA_W'(mem_wstrb[0]), DATA_W'(16'h00FF));
        end

        // Weights granted, one idle cycle, then pixel and weights: pixel wins and bursts from 1.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        cycleStep();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cycleStep();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
            cycleStep();
            compare("idle_gap_seq", 0, DATA_W'(grantsOf(0)), DATA_W'((c < 4) ? 3'b001 : 3'b010));
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 49) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0));
            cycleStep();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
